// File: rtl/ibex_rvfi_trace_buffer_if.sv
// rtl/ibex_rvfi_trace_buffer_if.sv - RVFI capture and drain port bundle for the trace buffer
// Purpose: groups the retirement (RVFI) fields and the valid/ready drain port.
// Ports (signals):
//   rvfi_valid, rvfi_pc_rdata, rvfi_insn, rvfi_rd_addr, rvfi_rd_wdata,
//   rvfi_trap, rvfi_intr      retirement fields, driven by the core side
//   rd_ready                  drain consumer ready, driven by the core side
//   rd_valid, rd_data         oldest record, driven by the buffer
// Modports: master = core/debug side, slave = trace buffer.
interface ibex_rvfi_trace_buffer_if;
   logic         rvfi_valid;
   logic [31:0]  rvfi_pc_rdata;
   logic [31:0]  rvfi_insn;
   logic [4:0]   rvfi_rd_addr;
   logic [31:0]  rvfi_rd_wdata;
   logic         rvfi_trap;
   logic         rvfi_intr;
   logic         rd_valid;
   logic         rd_ready;
   logic [102:0] rd_data;

   modport master (
      output rvfi_valid, rvfi_pc_rdata, rvfi_insn, rvfi_rd_addr, rvfi_rd_wdata,
             rvfi_trap, rvfi_intr, rd_ready,
      input  rd_valid, rd_data
   );

   modport slave (
      input  rvfi_valid, rvfi_pc_rdata, rvfi_insn, rvfi_rd_addr, rvfi_rd_wdata,
             rvfi_trap, rvfi_intr, rd_ready,
      output rd_valid, rd_data
   );
endinterface

// File: rtl/ibex_rvfi_trace_buffer.sv
// rtl/ibex_rvfi_trace_buffer.sv - circular retirement trace buffer with PC trigger
// Purpose: captures {trap,intr,rd_addr,pc,insn,rd_wdata} of each retired
//   instruction into a Depth-entry ring, in wrap or stop-when-full mode, with
//   an optional PC trigger followed by a post-trigger record count. Records
//   drain oldest-first through a show-ahead valid/ready port.
// Ports:
//   clk_i, rst_ni     clock, asynchronous active-low reset
//   bus               RVFI inputs and drain port (slave modport)
//   cfg_en_i          capture enable (level)
//   cfg_stop_full_i   1: drop new records when full, 0: overwrite oldest
//   cfg_trig_en_i     enable PC trigger
//   cfg_trig_pc_i     trigger PC
//   cfg_post_cnt_i    records captured after the trigger record
//   clear_i           synchronous flush of buffer, counters and state
//   level_o           entries held, 0..Depth
//   overflow_o        sticky: a record was dropped or overwritten
//   drop_cnt_o        lost records, saturating
//   triggered_o       sticky: trigger record captured
//   done_o            capture finished after trigger
module ibex_rvfi_trace_buffer #(
   parameter int unsigned Depth    = 16,
   parameter int unsigned PostCntW = 8
) (
   input  logic                       clk_i,
   input  logic                       rst_ni,
   ibex_rvfi_trace_buffer_if.slave    bus,
   input  logic                       cfg_en_i,
   input  logic                       cfg_stop_full_i,
   input  logic                       cfg_trig_en_i,
   input  logic [31:0]                cfg_trig_pc_i,
   input  logic [PostCntW-1:0]        cfg_post_cnt_i,
   input  logic                       clear_i,
   output logic [$clog2(Depth):0]     level_o,
   output logic                       overflow_o,
   output logic [15:0]                drop_cnt_o,
   output logic                       triggered_o,
   output logic                       done_o
);

   localparam int unsigned AW    = $clog2(Depth);
   localparam int unsigned LvlW  = AW + 1;
   localparam int unsigned DataW = 103;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARMED = 2'd1,
      POST  = 2'd2,
      DONE  = 2'd3
   } state_e;

   state_e              state_q, state_d;
   logic [AW-1:0]       wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]       rd_ptr_q, rd_ptr_d;
   logic [LvlW-1:0]     level_q, level_d;
   logic                overflow_q, overflow_d;
   logic [15:0]         drop_cnt_q, drop_cnt_d;
   logic                triggered_q, triggered_d;
   logic [PostCntW-1:0] cnt_q, cnt_d;
   logic                done_q, done_d;

   logic [DataW-1:0]    mem_q [Depth];
   logic                mem_we;
   logic [DataW-1:0]    wr_rec;

   logic push, pop, full, trig_hit;

   assign wr_rec = {bus.rvfi_trap, bus.rvfi_intr, bus.rvfi_rd_addr,
                    bus.rvfi_pc_rdata, bus.rvfi_insn, bus.rvfi_rd_wdata};

   assign full     = (level_q == LvlW'(Depth));
   assign push     = bus.rvfi_valid && ((state_q == ARMED) || (state_q == POST));
   assign pop      = bus.rd_ready && (level_q != '0);
   assign trig_hit = cfg_trig_en_i && (bus.rvfi_pc_rdata == cfg_trig_pc_i);

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      level_d     = level_q;
      overflow_d  = overflow_q;
      drop_cnt_d  = drop_cnt_q;
      triggered_d = triggered_q;
      cnt_d       = cnt_q;
      mem_we      = 1'b0;

      if (clear_i) begin
         // Flush wins over any capture or pop arriving in the same cycle.
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         level_d     = '0;
         overflow_d  = 1'b0;
         drop_cnt_d  = '0;
         triggered_d = 1'b0;
         cnt_d       = '0;
         state_d     = cfg_en_i ? ARMED : IDLE;
      end else begin
         if (push) begin
            if (!full || pop) begin
               // A simultaneous pop frees the slot, so a full buffer loses nothing.
               mem_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + AW'(1);
               if (pop) begin
                  rd_ptr_d = rd_ptr_q + AW'(1);
               end else begin
                  level_d = level_q + LvlW'(1);
               end
            end else begin
               overflow_d = 1'b1;
               if (drop_cnt_q != 16'hFFFF) begin
                  drop_cnt_d = drop_cnt_q + 16'd1;
               end
               if (!cfg_stop_full_i) begin
                  // Overwrite: wr_ptr == rd_ptr when full, so both advance together.
                  mem_we   = 1'b1;
                  wr_ptr_d = wr_ptr_q + AW'(1);
                  rd_ptr_d = rd_ptr_q + AW'(1);
               end
            end
         end else if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            level_d  = level_q - LvlW'(1);
         end

         unique case (state_q)
            IDLE: begin
               if (cfg_en_i) state_d = ARMED;
            end
            ARMED: begin
               if (!cfg_en_i) begin
                  state_d = IDLE;
               end else if (push && trig_hit) begin
                  triggered_d = 1'b1;
                  cnt_d       = cfg_post_cnt_i;
                  state_d     = (cfg_post_cnt_i == '0) ? DONE : POST;
               end
            end
            POST: begin
               if (!cfg_en_i) begin
                  state_d = IDLE;
               end else if (push) begin
                  cnt_d = cnt_q - PostCntW'(1);
                  if (cnt_q == PostCntW'(1)) state_d = DONE;
               end
            end
            DONE: begin
               if (!cfg_en_i) state_d = IDLE;
            end
            default: state_d = IDLE;
         endcase
      end

      done_d = (state_d == DONE);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         level_q     <= '0;
         overflow_q  <= 1'b0;
         drop_cnt_q  <= '0;
         triggered_q <= 1'b0;
         cnt_q       <= '0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         level_q     <= level_d;
         overflow_q  <= overflow_d;
         drop_cnt_q  <= drop_cnt_d;
         triggered_q <= triggered_d;
         cnt_q       <= cnt_d;
         done_q      <= done_d;
      end
   end

   // Storage is deliberately left unreset; only pointers define validity.
   always_ff @(posedge clk_i) begin
      if (mem_we) begin
         mem_q[wr_ptr_q] <= wr_rec;
      end
   end

   assign bus.rd_valid = (level_q != '0);
   assign bus.rd_data  = mem_q[rd_ptr_q];
   assign level_o      = level_q;
   assign overflow_o   = overflow_q;
   assign drop_cnt_o   = drop_cnt_q;
   assign triggered_o  = triggered_q;
   assign done_o       = done_q;

endmodule
